axi4_mem_ctrl: RTL and testbench

AXI4 slave controller that sequences the single-port `axi4_memory` word array (DEPTH words, one access per cycle, 1-cycle read latency) on behalf of one AXI4 master. It accepts INCR bursts on the write and read channels and serialises them onto the memory port one transaction at a time. Simultaneous write and read requests are arbitrated round-robin. Beats whose address lies outside the array, and unsupported attributes, complete with SLVERR.

---
 rtl/axi4_mem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_axi4_mem_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mem_ctrl.sv
// AXI4 slave front-end for a single-port word memory (1-cycle read latency).
// Serialises INCR write and read bursts onto the memory port one at a time,
// arbitrating simultaneous requests round-robin. Out-of-range beats and bursts
// with unsupported burst type or size complete with SLVERR.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   aw*, w*, b*                   AXI4 write address / data / response channels
//   ar*, r*                       AXI4 read address / data channels
//   mem_en, mem_we, mem_addr,     memory port (word index, one access per cycle)
//   mem_wdata, mem_rdata
module axi4_mem_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned DEPTH          = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic [7:0]                arlen,
  input  logic [2:0]                arsize,
  input  logic [1:0]                arburst,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rlast,
  output logic                      rvalid,
  input  logic                      rready,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  // One bit wider than the byte-address word field so base + beat never wraps.
  localparam int unsigned IdxW     = ADDR_WIDTH - 1;
  localparam logic [2:0]  SizeFull = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [1:0]  RespOkay = 2'b00;
  localparam logic [1:0]  RespErr  = 2'b10;

  typedef enum logic [2:0] {StIdle, StWrData, StWrResp, StRdReq, StRdData} state_e;

  state_e          state_q, state_d;
  logic            pri_q, pri_d;      // 0: write has priority, 1: read
  logic [IdxW-1:0] base_q, base_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      beat_q, beat_d;
  logic            legal_q, legal_d;
  logic            err_q, err_d;

  logic [IdxW-1:0] idx;
  logic            beat_ok;
  logic            last_beat;

  assign idx       = base_q + IdxW'(beat_q);
  assign beat_ok   = (idx < IdxW'(DEPTH)) && legal_q;
  assign last_beat = (beat_q == len_q);

  always_comb begin
    state_d   = state_q;
    pri_d     = pri_q;
    base_d    = base_q;
    len_d     = len_q;
    beat_d    = beat_q;
    legal_d   = legal_q;
    err_d     = err_q;
    awready   = 1'b0;
    arready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    bresp     = RespOkay;
    rvalid    = 1'b0;
    rresp     = RespOkay;
    rlast     = 1'b0;
    rdata     = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = idx[MEM_ADDR_WIDTH-1:0];
    mem_wdata = wdata;

    unique case (state_q)
      StIdle: begin
        awready = awvalid && (!arvalid || !pri_q);
        arready = arvalid && (!awvalid || pri_q);
        if (awready) begin
          base_d  = IdxW'(awaddr[ADDR_WIDTH-1:2]);
          len_d   = awlen;
          legal_d = (awburst == 2'b01) && (awsize == SizeFull);
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = StWrData;
        end else if (arready) begin
          base_d  = IdxW'(araddr[ADDR_WIDTH-1:2]);
          len_d   = arlen;
          legal_d = (arburst == 2'b01) && (arsize == SizeFull);
          beat_d  = '0;
          state_d = StRdReq;
        end
      end
      StWrData: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_en = beat_ok;
          mem_we = 1'b1;
          // Burst length comes from awlen; wlast only contributes to the error flag.
          if (!beat_ok || (wlast != last_beat)) err_d = 1'b1;
          if (last_beat) state_d = StWrResp;
          else           beat_d  = beat_q + 8'd1;
        end
      end
      StWrResp: begin
        bvalid = 1'b1;
        bresp  = err_q ? RespErr : RespOkay;
        if (bready) begin
          pri_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StRdReq: begin
        mem_en  = beat_ok;
        state_d = StRdData;
      end
      StRdData: begin
        rvalid = 1'b1;
        // mem_rdata is held by the memory while mem_en is low, so rdata is stable on stall.
        rdata  = beat_ok ? mem_rdata : '0;
        rresp  = beat_ok ? RespOkay : RespErr;
        rlast  = last_beat;
        if (rready) begin
          if (last_beat) begin
            pri_d   = 1'b0;
            state_d = StIdle;
          end else begin
            beat_d  = beat_q + 8'd1;
            state_d = StRdReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pri_q   <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      legal_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      base_q  <= base_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      legal_q <= legal_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axi4_mem_ctrl.sv
// Self-checking bench for axi4_mem_ctrl: behavioural memory plus a scoreboard of
// expected memory accesses, B responses and R beats derived from a reference array.
module tb_axi4_mem_ctrl;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic        awvalid, awready, arvalid, arready;
  logic [31:0] wdata, rdata;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, rlast, rvalid, rready;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  axi4_mem_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_ADDR_WIDTH(10), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural single-port memory.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct packed {logic we; logic [9:0] addr; logic [31:0] data;} acc_t;
  typedef struct packed {logic [31:0] data; logic [1:0] resp; logic last;} rbeat_t;

  acc_t        acc_q[$];
  rbeat_t      r_q[$];
  logic [1:0]  b_q[$];
  logic [31:0] model [DEPTH];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          mon_off = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void exp_write(input logic [15:0] addr, input int len, input logic [2:0] size,
                                    input logic [1:0] burst, input logic [31:0] d0, input int wl);
    int base;
    int idx;
    bit legal;
    bit err;
    base  = int'(addr) >> 2;
    legal = (burst == 2'b01) && (size == 3'd2);
    err   = (wl != len);
    for (int i = 0; i <= len; i++) begin
      idx = base + i;
      if (idx < DEPTH && legal) begin
        acc_q.push_back('{we: 1'b1, addr: idx[9:0], data: d0 + 32'(i)});
        model[idx] = d0 + 32'(i);
      end else begin
        err = 1'b1;
      end
    end
    b_q.push_back(err ? 2'b10 : 2'b00);
  endfunction

  function automatic void exp_read(input logic [15:0] addr, input int len, input logic [2:0] size,
                                   input logic [1:0] burst);
    int base;
    int idx;
    bit ok;
    base = int'(addr) >> 2;
    for (int i = 0; i <= len; i++) begin
      idx = base + i;
      ok  = (idx < DEPTH) && (burst == 2'b01) && (size == 3'd2);
      if (ok) acc_q.push_back('{we: 1'b0, addr: idx[9:0], data: 32'd0});
      r_q.push_back('{data: ok ? model[idx] : 32'd0, resp: ok ? 2'b00 : 2'b10, last: i == len});
    end
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!mon_off && !rst) begin
      if (mem_en) begin
        if (acc_q.size() == 0) check_eq("mem_unexpected_en", mem_en, 1'b0);
        else begin
          acc_t a;
          a = acc_q.pop_front();
          check_eq("mem_we", mem_we, a.we);
          check_eq("mem_addr", mem_addr, a.addr);
          if (a.we) check_eq("mem_wdata", mem_wdata, a.data);
        end
      end
      if (bvalid && bready) begin
        if (b_q.size() == 0) check_eq("b_unexpected", bvalid, 1'b0);
        else check_eq("bresp", bresp, b_q.pop_front());
      end
      if (rvalid) begin
        if (r_q.size() == 0) check_eq("r_unexpected", rvalid, 1'b0);
        else begin
          rbeat_t e;
          e = r_q[0];
          if (rready) begin
            void'(r_q.pop_front());
            check_eq("rdata", rdata, e.data);
            check_eq("rresp", rresp, e.resp);
            check_eq("rlast", rlast, e.last);
          end else begin
            check_eq("rdata_stall", rdata, e.data);
          end
        end
      end
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return awready;
      1:       return arready;
      2:       return wready;
      default: return bvalid;
    endcase
  endfunction

  // Wait (bounded) for a handshake signal, then step past the edge that takes it.
  task automatic wait_hi(input int sel, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!sig(sel) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!sig(sel)) check_eq(tag, sig(sel), 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [15:0] addr, input int len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [31:0] d0, input int wl);
    awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    wait_hi(0, "aw_timeout");
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wvalid = 1'b1;
      wdata  = d0 + 32'(i);
      wlast  = (i == wl);
      wait_hi(2, "w_timeout");
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    bready = 1'b1;
    wait_hi(3, "b_timeout");
    bready = 1'b0;
  endtask

  task automatic drive_read(input logic [15:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input bit stall);
    int got;
    int k;
    int n;
    araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    wait_hi(1, "ar_timeout");
    arvalid = 1'b0;
    got = 0; k = 0; n = 0;
    while (got <= len && n < 400) begin
      rready = stall ? (k % 2 == 0) : 1'b1;
      @(negedge clk);
      if (rvalid) begin
        k++;
        if (rready) got++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    rready = 1'b0;
    if (got <= len) check_eq("r_timeout", 64'(got), 64'(len + 1));
  endtask

  task automatic check_idle_outputs(input string pfx);
    check_eq({pfx, "_awready"}, awready, 1'b0);
    check_eq({pfx, "_wready"}, wready, 1'b0);
    check_eq({pfx, "_bvalid"}, bvalid, 1'b0);
    check_eq({pfx, "_rvalid"}, rvalid, 1'b0);
    check_eq({pfx, "_rlast"}, rlast, 1'b0);
    check_eq({pfx, "_rdata"}, rdata, 32'd0);
    check_eq({pfx, "_resp"}, {bresp, rresp}, 4'd0);
    check_eq({pfx, "_mem_en"}, {mem_en, mem_we}, 2'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rst = 1'b1;
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    #2;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single write then read.
    exp_write(16'h0010, 0, 3'd2, 2'b01, 32'hDEADBEEF, 0);
    drive_write(16'h0010, 0, 3'd2, 2'b01, 32'hDEADBEEF, 0);
    exp_read(16'h0010, 0, 3'd2, 2'b01);
    drive_read(16'h0010, 0, 3'd2, 2'b01, 1'b0);

    // INCR burst, read back with rready toggling.
    exp_write(16'h0100, 3, 3'd2, 2'b01, 32'd1, 3);
    drive_write(16'h0100, 3, 3'd2, 2'b01, 32'd1, 3);
    exp_read(16'h0100, 3, 3'd2, 2'b01);
    drive_read(16'h0100, 3, 3'd2, 2'b01, 1'b1);

    // Burst straddling the end of the array.
    exp_write(16'h0FFC, 1, 3'd2, 2'b01, 32'hA5A50000, 1);
    drive_write(16'h0FFC, 1, 3'd2, 2'b01, 32'hA5A50000, 1);
    exp_read(16'h0FFC, 1, 3'd2, 2'b01);
    drive_read(16'h0FFC, 1, 3'd2, 2'b01, 1'b0);

    // Illegal attributes.
    exp_write(16'h0200, 1, 3'd2, 2'b00, 32'h11, 1);
    drive_write(16'h0200, 1, 3'd2, 2'b00, 32'h11, 1);
    exp_write(16'h0204, 0, 3'd1, 2'b01, 32'h22, 0);
    drive_write(16'h0204, 0, 3'd1, 2'b01, 32'h22, 0);
    exp_read(16'h0010, 1, 3'd2, 2'b10);
    drive_read(16'h0010, 1, 3'd2, 2'b10, 1'b0);

    // wlast on beat 1 of a 4-beat burst.
    exp_write(16'h0300, 3, 3'd2, 2'b01, 32'h30, 1);
    drive_write(16'h0300, 3, 3'd2, 2'b01, 32'h30, 1);

    // Reset in the middle of a stalled read burst.
    mon_off = 1'b1;
    araddr = 16'h0100; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    wait_hi(1, "ar_timeout");
    arvalid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("pre_rst_rvalid", rvalid, 1'b1);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_off = 1'b0;

    // Arbitration after reset: write, then read, then write.
    exp_write(16'h0500, 1, 3'd2, 2'b01, 32'h5000, 1);
    exp_read(16'h0500, 1, 3'd2, 2'b01);
    exp_write(16'h0600, 0, 3'd2, 2'b01, 32'h6000, 0);
    fork
      begin
        drive_write(16'h0500, 1, 3'd2, 2'b01, 32'h5000, 1);
        drive_write(16'h0600, 0, 3'd2, 2'b01, 32'h6000, 0);
      end
      drive_read(16'h0500, 1, 3'd2, 2'b01, 1'b0);
    join

    repeat (3) @(posedge clk);
    check_eq("acc_left", 64'(acc_q.size()), 64'd0);
    check_eq("b_left", 64'(b_q.size()), 64'd0);
    check_eq("r_left", 64'(r_q.size()), 64'd0);
    check_eq("mem_1023", mem[1023], 32'hA5A50000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
